// File: rtl/call_request_bank.sv
// call_request_bank
// Per-floor request register for the elevator controller. Every raw cabin and hall button is
// synchronised and debounced. A debounced press sets a request: cabin presses toggle, hall
// presses set only. The controller's service levels clear requests. Summary flags and a
// popcount are registered on the same edge as the request bits.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cur_floor, door_open        cabin position and door state
//   btn_cab/btn_up/btn_down     raw asynchronous buttons, one bit per floor
//   svc_cab/svc_up/svc_down     synchronous clear levels, one bit per floor
//   req_cab/req_up/req_down     pending requests (registered)
//   req_above/below/here        any request above/below/at cur_floor (registered)
//   new_req                     one-cycle pulse when any request bit rises
//   pending_count               number of set request bits (registered)
module call_request_bank #(
    parameter int unsigned FLOORS   = 8,
    parameter int unsigned FLOOR_W  = 3,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               door_open,
    input  logic [FLOORS-1:0]  btn_cab,
    input  logic [FLOORS-1:0]  btn_up,
    input  logic [FLOORS-1:0]  btn_down,
    input  logic [FLOORS-1:0]  svc_cab,
    input  logic [FLOORS-1:0]  svc_up,
    input  logic [FLOORS-1:0]  svc_down,
    output logic [FLOORS-1:0]  req_cab,
    output logic [FLOORS-1:0]  req_up,
    output logic [FLOORS-1:0]  req_down,
    output logic               req_above,
    output logic               req_below,
    output logic               req_here,
    output logic               new_req,
    output logic [CNT_W-1:0]   pending_count
);

    localparam int unsigned NIN = 3 * FLOORS;

    // Flattened input order: {down, up, cab}.
    logic [NIN-1:0]        raw;
    logic [NIN-1:0]        s1_q, s2_q;
    logic [NIN-1:0]        db_q, db_d;
    logic [NIN-1:0][7:0]   cnt_q, cnt_d;
    logic [NIN-1:0]        press;

    logic [FLOORS-1:0]     press_cab, press_up, press_down;
    logic [FLOORS-1:0]     blocked;
    logic [FLOORS-1:0]     cab_d, up_d, down_d, any_d;
    logic                  above_d, below_d, here_d, new_d;
    logic [CNT_W-1:0]      count_d;
    logic [NIN-1:0]        all_d;
    logic [31:0]           cf;

    assign raw        = {btn_down, btn_up, btn_cab};
    assign press_cab  = press[FLOORS-1:0];
    assign press_up   = press[2*FLOORS-1:FLOORS];
    assign press_down = press[3*FLOORS-1:2*FLOORS];
    assign cf         = 32'(cur_floor);

    // Debouncer: db flips once s2 has disagreed with it for DEBOUNCE consecutive cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        press = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == 8'(DEBOUNCE - 1)) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                    press[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Request next state; the service clear is applied last so it beats any press.
    always_comb begin
        for (int unsigned i = 0; i < FLOORS; i++) begin
            blocked[i] = door_open && (cf == i);

            cab_d[i] = req_cab[i];
            if (press_cab[i] && !blocked[i]) cab_d[i] = ~req_cab[i];
            if (svc_cab[i]) cab_d[i] = 1'b0;

            up_d[i] = req_up[i];
            if (press_up[i] && !blocked[i]) up_d[i] = 1'b1;
            if (svc_up[i]) up_d[i] = 1'b0;

            down_d[i] = req_down[i];
            if (press_down[i] && !blocked[i]) down_d[i] = 1'b1;
            if (svc_down[i]) down_d[i] = 1'b0;
        end
        // No hall call beyond the shaft ends.
        up_d[FLOORS-1] = 1'b0;
        down_d[0]      = 1'b0;
    end

    // Summary from next-state vectors. An out-of-range cur_floor naturally places every
    // floor below it, giving here = 0, above = 0, below = any.
    always_comb begin
        any_d   = cab_d | up_d | down_d;
        all_d   = {down_d, up_d, cab_d};
        above_d = 1'b0;
        below_d = 1'b0;
        here_d  = 1'b0;
        count_d = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (any_d[i]) begin
                if (i > cf)  above_d = 1'b1;
                if (i < cf)  below_d = 1'b1;
                if (i == cf) here_d  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NIN; i++) begin
            count_d = count_d + CNT_W'(all_d[i]);
        end
        new_d = |(all_d & ~{req_down, req_up, req_cab});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            db_q          <= '0;
            cnt_q         <= '0;
            req_cab       <= '0;
            req_up        <= '0;
            req_down      <= '0;
            req_above     <= 1'b0;
            req_below     <= 1'b0;
            req_here      <= 1'b0;
            new_req       <= 1'b0;
            pending_count <= '0;
        end else begin
            s1_q          <= raw;
            s2_q          <= s1_q;
            db_q          <= db_d;
            cnt_q         <= cnt_d;
            req_cab       <= cab_d;
            req_up        <= up_d;
            req_down      <= down_d;
            req_above     <= above_d;
            req_below     <= below_d;
            req_here      <= here_d;
            new_req       <= new_d;
            pending_count <= count_d;
        end
    end

endmodule

// File: tb/tb_call_request_bank.sv
module tb_call_request_bank;

    localparam int unsigned FLOORS   = 8;
    localparam int unsigned FLOOR_W  = 3;
    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned CNT_W    = 5;
    localparam int          LAT      = DEBOUNCE + 2;

    localparam int S_CAB = 0, S_UP = 1, S_DN = 2, S_ABV = 3, S_BLW = 4, S_HERE = 5,
                   S_NEW = 6, S_CNT = 7;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [FLOOR_W-1:0] cur_floor = '0;
    logic               door_open = 1'b0;
    logic [FLOORS-1:0]  btn_cab = '0, btn_up = '0, btn_down = '0;
    logic [FLOORS-1:0]  svc_cab = '0, svc_up = '0, svc_down = '0;
    logic [FLOORS-1:0]  req_cab, req_up, req_down;
    logic               req_above, req_below, req_here, new_req;
    logic [CNT_W-1:0]   pending_count;

    call_request_bank #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W),
        .DEBOUNCE(DEBOUNCE),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cur_floor    (cur_floor),
        .door_open    (door_open),
        .btn_cab      (btn_cab),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .svc_cab      (svc_cab),
        .svc_up       (svc_up),
        .svc_down     (svc_down),
        .req_cab      (req_cab),
        .req_up       (req_up),
        .req_down     (req_down),
        .req_above    (req_above),
        .req_below    (req_below),
        .req_here     (req_here),
        .new_req      (new_req),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] act(int sel);
        case (sel)
            S_CAB:   return 32'(req_cab);
            S_UP:    return 32'(req_up);
            S_DN:    return 32'(req_down);
            S_ABV:   return 32'(req_above);
            S_BLW:   return 32'(req_below);
            S_HERE:  return 32'(req_here);
            S_NEW:   return 32'(new_req);
            S_CNT:   return 32'(pending_count);
            default: return '0;
        endcase
    endfunction

    // Expected value for output 'sel' as sampled at the negedge dc cycles from now.
    task automatic expv(int dc, int sel, logic [31:0] v, string nm);
        sbq.push_back('{cyc + dc, sel, v, nm});
    endtask

    task automatic exp_all_zero(int dc, string nm);
        for (int s = S_CAB; s <= S_CNT; s++) expv(dc, s, 32'd0, nm);
    endtask

    task automatic wait_n(int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: outputs are registered, so sample on the falling edge.
    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].at <= cyc) begin
                logic [31:0] a;
                a = act(sbq[k].sel);
                total++;
                if (sbq[k].at < cyc || a !== sbq[k].val) begin
                    bad++;
                    $display("FAIL %s (cycle %0d sel %0d): got 0x%0h expected 0x%0h",
                             sbq[k].name, sbq[k].at, sbq[k].sel, a, sbq[k].val);
                end
                sbq.delete(k);
            end
        end
    end

    initial begin
        // Reset state.
        exp_all_zero(1, "reset_state");
        wait_n(2);
        reset = 1'b1;
        wait_n(1);

        // Debounced press: visible LAT cycles after the drive, not before.
        btn_cab[5] = 1'b1;
        expv(LAT - 1, S_CAB, 32'h00, "t1_not_early");
        expv(LAT - 1, S_NEW, 32'd0,  "t1_no_early_new");
        expv(LAT,     S_CAB, 32'h20, "t1_req_cab");
        expv(LAT,     S_NEW, 32'd1,  "t1_new_req");
        expv(LAT,     S_ABV, 32'd1,  "t1_above");
        expv(LAT,     S_BLW, 32'd0,  "t1_below");
        expv(LAT,     S_CNT, 32'd1,  "t1_count");
        expv(LAT + 1, S_NEW, 32'd0,  "t1_new_one_cycle");
        expv(LAT + 1, S_CAB, 32'h20, "t1_hold");
        wait_n(8);
        total++;
        if (req_cab !== 8'h20) begin
            bad++;
            $display("FAIL t1_direct_cab: got 0x%0h expected 0x20", req_cab);
        end
        btn_cab[5] = 1'b0;
        expv(8, S_CAB, 32'h20, "t1_release_no_effect");
        wait_n(8);
        svc_cab[5] = 1'b1;
        expv(1, S_CAB, 32'h00, "t1_svc_clear");
        expv(1, S_CNT, 32'd0,  "t1_svc_count");
        wait_n(1);
        svc_cab[5] = 1'b0;
        wait_n(1);

        // Bounce shorter than DEBOUNCE: no change.
        btn_cab[3] = 1'b1;
        for (int d = 1; d <= 12; d++) begin
            expv(d, S_CAB, 32'h00, "t2_bounce_cab");
            expv(d, S_NEW, 32'd0,  "t2_bounce_new");
        end
        wait_n(3);
        btn_cab[3] = 1'b0;
        wait_n(12);
        // Clean press sets, second clean press cancels.
        btn_cab[3] = 1'b1;
        expv(LAT, S_CAB, 32'h08, "t2_set");
        expv(LAT, S_CNT, 32'd1,  "t2_set_count");
        wait_n(8);
        total++;
        if (req_cab !== 8'h08) begin
            bad++;
            $display("FAIL t2_direct_cab: got 0x%0h expected 0x08", req_cab);
        end
        btn_cab[3] = 1'b0;
        wait_n(8);
        btn_cab[3] = 1'b1;
        expv(LAT - 1, S_CAB, 32'h08, "t2_before_cancel");
        expv(LAT,     S_CAB, 32'h00, "t2_cancel");
        expv(LAT,     S_CNT, 32'd0,  "t2_cancel_count");
        expv(LAT,     S_NEW, 32'd0,  "t2_cancel_no_new");
        wait_n(8);
        btn_cab[3] = 1'b0;
        wait_n(8);

        // Presses at the open-door floor and at the shaft ends are ignored.
        cur_floor  = 3'd2;
        door_open  = 1'b1;
        btn_cab[2] = 1'b1; btn_up[2] = 1'b1; btn_up[7] = 1'b1; btn_down[0] = 1'b1;
        for (int d = 1; d <= 12; d++) begin
            expv(d, S_CAB, 32'h00, "t3_blk_cab");
            expv(d, S_UP,  32'h00, "t3_blk_up");
            expv(d, S_DN,  32'h00, "t3_blk_down");
            expv(d, S_NEW, 32'd0,  "t3_blk_new");
        end
        wait_n(8);
        btn_cab[2] = 1'b0; btn_up[2] = 1'b0; btn_up[7] = 1'b0; btn_down[0] = 1'b0;
        wait_n(8);
        door_open  = 1'b0;
        btn_cab[2] = 1'b1; btn_up[2] = 1'b1; btn_up[7] = 1'b1; btn_down[0] = 1'b1;
        expv(LAT, S_CAB,  32'h04, "t3_open_cab");
        expv(LAT, S_UP,   32'h04, "t3_open_up");
        expv(LAT, S_DN,   32'h00, "t3_open_down");
        expv(LAT, S_NEW,  32'd1,  "t3_open_new");
        expv(LAT, S_CNT,  32'd2,  "t3_open_count");
        expv(LAT, S_HERE, 32'd1,  "t3_open_here");
        expv(LAT, S_ABV,  32'd0,  "t3_open_above");
        expv(LAT, S_BLW,  32'd0,  "t3_open_below");
        wait_n(8);
        total++;
        if (req_up !== 8'h04) begin
            bad++;
            $display("FAIL t3_direct_up: got 0x%0h expected 0x04", req_up);
        end
        btn_cab[2] = 1'b0; btn_up[2] = 1'b0; btn_up[7] = 1'b0; btn_down[0] = 1'b0;
        wait_n(8);
        svc_cab[2] = 1'b1; svc_up[2] = 1'b1;
        expv(1, S_CNT,  32'd0, "t3_svc_count");
        expv(1, S_HERE, 32'd0, "t3_svc_here");
        wait_n(1);
        svc_cab[2] = 1'b0; svc_up[2] = 1'b0;
        wait_n(1);

        // Held service clear beats a landing press.
        svc_up[4] = 1'b1;
        btn_up[4] = 1'b1;
        for (int d = 1; d <= 12; d++) begin
            expv(d, S_UP,  32'h00, "t4_clear_prio_up");
            expv(d, S_NEW, 32'd0,  "t4_clear_prio_new");
        end
        wait_n(8);
        btn_up[4] = 1'b0;
        wait_n(8);
        svc_up[4] = 1'b0;
        wait_n(1);
        btn_up[4] = 1'b1;
        expv(LAT, S_UP,  32'h10, "t4_fresh_up");
        expv(LAT, S_NEW, 32'd1,  "t4_fresh_new");
        wait_n(8);
        btn_up[4] = 1'b0;
        wait_n(8);
        svc_up[4] = 1'b1;
        expv(1, S_UP, 32'h00, "t4_svc");
        wait_n(1);
        svc_up[4] = 1'b0;
        wait_n(1);

        // Summary flags with requests at cab 1 and down 6.
        cur_floor   = 3'd0;
        btn_cab[1]  = 1'b1;
        btn_down[6] = 1'b1;
        expv(LAT, S_CAB, 32'h02, "t5_cab");
        expv(LAT, S_DN,  32'h40, "t5_down");
        expv(LAT, S_CNT, 32'd2,  "t5_count2");
        expv(LAT, S_NEW, 32'd1,  "t5_new");
        wait_n(8);
        total++;
        if (req_down !== 8'h40) begin
            bad++;
            $display("FAIL t5_direct_down: got 0x%0h expected 0x40", req_down);
        end
        btn_cab[1]  = 1'b0;
        btn_down[6] = 1'b0;
        wait_n(8);
        cur_floor = 3'd3;
        expv(1, S_ABV,  32'd1, "t5_f3_above");
        expv(1, S_BLW,  32'd1, "t5_f3_below");
        expv(1, S_HERE, 32'd0, "t5_f3_here");
        wait_n(2);
        cur_floor = 3'd6;
        expv(1, S_HERE, 32'd1, "t5_f6_here");
        expv(1, S_ABV,  32'd0, "t5_f6_above");
        expv(1, S_BLW,  32'd1, "t5_f6_below");
        wait_n(2);
        svc_down[6] = 1'b1;
        expv(1, S_HERE, 32'd0,  "t5_svc_here");
        expv(1, S_CNT,  32'd1,  "t5_svc_count1");
        expv(1, S_DN,   32'h00, "t5_svc_down");
        wait_n(1);
        svc_down[6] = 1'b0;
        wait_n(1);

        // Asynchronous reset in the middle of a debounce.
        cur_floor  = 3'd0;
        svc_cab[1] = 1'b1;
        expv(1, S_CNT, 32'd0, "t6_pre_clear");
        wait_n(1);
        svc_cab[1]  = 1'b0;
        btn_cab[4]  = 1'b1; btn_up[1] = 1'b1; btn_down[5] = 1'b1;
        expv(LAT, S_CNT, 32'd3,  "t6_three_count");
        expv(LAT, S_CAB, 32'h10, "t6_three_cab");
        expv(LAT, S_UP,  32'h02, "t6_three_up");
        expv(LAT, S_DN,  32'h20, "t6_three_down");
        wait_n(8);
        btn_cab[4]  = 1'b0; btn_up[1] = 1'b0; btn_down[5] = 1'b0;
        wait_n(8);
        btn_cab[0] = 1'b1;
        wait_n(3);
        // Reset goes low 1 time unit after the next rising edge; the following falling
        // edge comes before any clock edge inside reset.
        exp_all_zero(1, "t6_in_reset");
        expv(7, S_CAB, 32'h00, "t6_no_early_after_reset");
        expv(8, S_CAB, 32'h01, "t6_full_debounce");
        expv(8, S_CNT, 32'd1,  "t6_full_count");
        @(posedge clk);
        #1 reset = 1'b0;
        #10 reset = 1'b1;
        wait_n(10);
        btn_cab[0] = 1'b0;
        wait_n(8);

        wait_n(2);
        foreach (sbq[k]) begin
            total++;
            bad++;
            $display("FAIL %s (cycle %0d): never checked", sbq[k].name, sbq[k].at);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/call_request_bank.md
# call_request_bank

Parametrised request register for the elevator controller. Each floor has one cabin-button request and two hall-call requests (up and down). Every raw button input is synchronised and debounced, and presses become requests that cabin presses can cancel and served floors can clear. The block also provides registered summary flags (above, below, here) and a request count, which the direction/dispatch FSM uses to pick the next target.

## Interface
- FLOORS, 8, number of floors (2..16); floor 0 is the bottom floor.
- FLOOR_W, 3, width of the floor index; must satisfy 2^FLOOR_W >= FLOORS.
- DEBOUNCE, 4, consecutive stable cycles needed before a debounced state changes (1..255).
- CNT_W, 5, width of pending_count; must satisfy 2^CNT_W > 3*FLOORS.

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- cur_floor  in  FLOOR_W  floor the cabin is currently at
- door_open  in  1  cabin is stopped at cur_floor with doors open
- btn_cab  in  FLOORS  raw cabin buttons, asynchronous, bouncy
- btn_up  in  FLOORS  raw hall up buttons
- btn_down  in  FLOORS  raw hall down buttons
- svc_cab / svc_up / svc_down  in  FLOORS each  synchronous clear levels driven by the controller
- req_cab / req_up / req_down  out  FLOORS each  pending requests, registered
- req_above  out  1  any pending request at a floor > cur_floor
- req_below  out  1  any pending request at a floor < cur_floor
- req_here  out  1  any pending request at cur_floor
- new_req  out  1  one-cycle pulse: at least one request bit rose 0->1
- pending_count  out  CNT_W  number of set bits across all three request vectors

## Operation
- **Input conditioning.** Each of the 3*FLOORS raw inputs passes through a 2-flop synchroniser (s1, s2) and then a debouncer.
- **Debouncer.** Per-input counter plus debounced state db.
  - When s2 != db, the counter increments.
  - When s2 == db, the counter clears to 0.
  - When s2 != db and the counter == DEBOUNCE-1, db takes s2 and the counter clears. This is the "flip".
- **Press event.** A flip to 1. Releases (flip to 0) have no effect. The press acts on the request bit at the same edge as the flip.
- **Cabin request i.**
  - A press toggles req_cab[i]: it sets the bit if clear and cancels it if set.
  - A press is ignored when i == cur_floor and door_open == 1. That floor is already being served.
- **Hall request i.**
  - A press sets req_up[i] / req_down[i]. There is no cancel.
  - A press on req_up[FLOORS-1] is ignored; req_up[FLOORS-1] is always 0.
  - A press on req_down[0] is ignored; req_down[0] is always 0.
  - A hall press at cur_floor with door_open == 1 is ignored.
- **Service clear.** svc_*[i] == 1 forces the matching request bit to 0 at the next edge.
  - Clear has priority over a simultaneous press, including a cabin toggle-set.
  - Held svc keeps the bit at 0.
- **Summary flags.** req_above, req_below and req_here are registered. Each is computed from the next-state request vectors and the current cur_floor, so all three settle on the same edge as the request bits.
- **Out-of-range cur_floor.** If cur_floor >= FLOORS, req_here = 0 and req_below = 1 if any request is set. req_above = 0.
- **new_req.** Registered OR over all bits of (next & ~current), for all three vectors.
- **pending_count.** Registered popcount of the next-state vectors. It updates on the same edge as the requests.
- **Reset values (reset low).** All request vectors, flags, new_req and pending_count = 0. s1, s2, db and counters = 0. Reset mid-debounce discards any partial count.

## Timing
- Edge-to-request latency: raw input goes high and is stable before edge k.
  - s1 at k, s2 at k+1.
  - Flip and request update at edge k+DEBOUNCE+1.
  - So the request is visible DEBOUNCE+2 edges after the first sampling edge. With DEBOUNCE = 4, that is after edge k+5.
- Glitches: any bounce shorter than DEBOUNCE cycles on s2 produces no flip.
- Request lifetime: a request stays set until the first edge with its svc bit high, or a cabin cancel press.
- Timing of new_req, the flags and pending_count: all coincide with the request edge.
- cur_floor / door_open changes: reflected in the flags at the next edge.
- Concurrent presses: any number of presses in one cycle are all accepted. new_req is a single pulse.

## Test plan
- **Debounced press.** FLOORS=8, DEBOUNCE=4, cur_floor=0, door_open=0; btn_cab[5] goes high before edge 0 and is held.
  - req_cab = 8'h20 after edge 5, not before.
  - new_req pulses for one cycle; req_above=1; pending_count=1.
- **Bounce and cancel.**
  - btn_cab[3] pulses high for 3 cycles -> no change.
  - Clean press -> req_cab[3]=1.
  - Release, then a second clean press -> req_cab[3]=0 and pending_count returns to 0.
- **Blocking and end floors.**
  - cur_floor=2, door_open=1; presses on btn_cab[2], btn_up[2], btn_up[7], btn_down[0] -> all request vectors stay 0 and new_req never asserts.
  - Same presses with door_open=0 -> req_cab[2]=1 and req_up[2]=1, while req_up[7] and req_down[0] stay 0.
- **Clear priority.** svc_up[4] held high while btn_up[4]'s debounced press lands -> req_up[4] stays 0 and new_req stays 0. After svc_up[4] drops, a fresh press -> req_up[4]=1.
- **Summary flags.** Requests at req_cab[1] and req_down[6].
  - cur_floor=3 -> above=1, below=1, here=0.
  - cur_floor=6 -> here=1, above=0.
  - Assert svc_down[6] -> here=0 next edge; pending_count goes from 2 to 1.
- **Asynchronous reset mid-operation.** Three requests set, with btn_cab[0] halfway through debounce; reset low for 1 cycle, not aligned to clk.
  - All outputs = 0 immediately.
  - After release, btn_cab[0] (still held) needs a full DEBOUNCE+2 edges to set req_cab[0].
